mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Responder end of the CPU halfword memory bus: synchronous on-chip RAM that serves the CPU's `mem_en`/`rd_en`/`wr_en` requests.
- Storage is halfword-organised, with per-byte write enables and one-cycle registered read data.
- After reset, an internal clear sequencer zeroes the whole array before the bus is serviced.
- Misaligned accesses are flagged.
- Instantiated at top level beside cpu; cpu `o_mem_*` connect to `i_mem_*`, and `o_mem_do` connects to cpu `i_mem_do`.

Parameters:
- MEM_DEPTH, 2**12, number of 16-bit halfwords stored.
- ADDR_WIDTH, $clog2(MEM_DEPTH*2), byte-address width (localparam).
- CLEAR_ON_RESET, 1, 1 = run clear sequence after reset; 0 = ready immediately, contents undefined.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- i_mem_di  in  [0:1][7:0]  write data; lane 0 = even byte, lane 1 = odd byte.
- i_mem_addr  in  ADDR_WIDTH  byte address; halfword index = addr[ADDR_WIDTH-1:1].
- i_mem_en  in  1  access qualifier; rd/wr ignored when 0.
- i_mem_rd_en  in  1  read request.
- i_mem_wr_en  in  [0:1]  per-lane write enable.
- o_mem_do  out  [0:1][7:0]  registered read data.
- o_ready  out  1  1 = clear finished, bus serviced.
- o_err  out  1  one-cycle pulse on misaligned or dropped access.

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst` is synchronous and active-low. It is sampled on the clk edge; while `rst`=0 the block is held in reset.
- Reset values: `o_mem_do`=16'h0000, `o_ready`=0, `o_err`=0, clear counter=0, state=CLEAR (or READY when CLEAR_ON_RESET=0).
- FSM states:
  - CLEAR:
    - One halfword per cycle, writing 16'h0000 at counter index.
    - Counter increments 0 .. MEM_DEPTH-1.
    - On index MEM_DEPTH-1 → READY the next cycle.
    - Clear takes exactly MEM_DEPTH cycles after `rst` deasserts.
    - Bus requests are ignored; each cycle with `i_mem_en`=1 and a rd or wr request pulses `o_err` the next cycle.
  - READY: services the bus; stays here until reset.
- Reset asserted mid-CLEAR: counter returns to 0 and the clear restarts from index 0 after release.
- Write (READY, `en`=1):
  - Lane k of halfword [addr>>1] takes `i_mem_di[k]` when `i_mem_wr_en[k]`=1.
  - Lanes with enable 0 are unchanged.
  - Data is visible to reads issued from the next cycle onward.
- Read (READY, `en`=1, `rd_en`=1):
  - `o_mem_do` = mem[addr>>1], valid the cycle after the request (latency 1).
  - `o_mem_do` holds its last value when no read is issued.
- Simultaneous rd and wr to the same halfword in one cycle: read-first. `o_mem_do` returns old contents; the write commits.
- Misaligned access: `addr[0]`=1 with rd or wr while READY.
  - The access is still performed at halfword index addr>>1; addr[0] is ignored.
  - `o_err`=1 in the following cycle.
- `en`=0: no state change, `o_mem_do` holds, `o_err`=0.
- Wrap-around: none. Index width is exactly ADDR_WIDTH-1 bits, so all indices are valid.

Decomposition:
- Package mem_pkg:
  - typedef halfword_t = logic [0:1][7:0].
  - typedef mem_state_t enum {CLEAR, READY}.
  - Constants LANE_EVEN=0, LANE_ODD=1.
  - Shared with cpu/mem_ctrl for bus typing.
- Sub-module mem_lane: 8-bit × MEM_DEPTH synchronous single-port RAM with write enable and registered read-first output.
  - Instantiated twice, one per lane.
  - The FSM muxes the clear address and data into both instances.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, MEM_DEPTH=16: `o_ready` rises exactly 16 cycles after `rst`→1. Reads of every address 0..30 step 2 return 16'h0000.
- Write addr 0x004, di={8'hAB,8'hCD}, wr_en=2'b11; next cycle read 0x004 → `o_mem_do`={AB,CD} one cycle later. Then write wr_en=2'b01 with di={8'h11,8'h22}; read → {AB,22}.
- Same cycle: wr 0x008 {12,34} and rd 0x008, prior contents {00,00} → `o_mem_do`={00,00}. A following read returns {12,34}.
- Read 0x007 (misaligned) after a write of {5A,A5} at 0x006 → `o_mem_do`={5A,A5}, `o_err` pulses 1 for exactly one cycle.
- Drive rd at 0x000 during CLEAR → `o_err` pulse, no `o_mem_do` change. Pull `rst`=0 at counter=7, release → `o_ready` rises MEM_DEPTH cycles after release.
- `en`=0 with rd_en=1, wr_en=2'b11 → memory and `o_mem_do` unchanged, `o_err`=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared bus typing for the CPU halfword memory bus: lane-ordered halfword type,
// responder state encoding and lane indices.
package mem_pkg;

   typedef logic [0:1][7:0] halfword_t;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } mem_state_t;

   localparam int LANE_EVEN = 0;
   localparam int LANE_ODD  = 1;

endpackage

// File: rtl/mem_lane.sv
// One byte lane of the responder RAM: DEPTH x 8 synchronous single-port memory
// with a write enable and a registered, read-first output.
module mem_lane #(
   parameter int DEPTH     = 4096,
   parameter int IDX_WIDTH = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic                 re,
   input  logic [IDX_WIDTH-1:0] idx,
   input  logic [7:0]           di,
   output logic [7:0]           dout
);

   logic [7:0] mem [DEPTH];

   // NOTE: the array carries no reset so it can map onto a RAM macro; the clear
   // sequencer in the top level zeroes it after reset instead.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= di;
      end
   end

   // NOTE: non-blocking assignments make a same-cycle read return the old
   // contents, so read-first behaviour falls out of the two separate blocks.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dout <= '0;
      end else if (re) begin
         dout <= mem[idx];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Responder end of the CPU halfword memory bus: two byte-lane RAMs, a post-reset
// clear sequencer, and a one-cycle error pulse for misaligned or dropped accesses.
module mem_responder
   import mem_pkg::*;
#(
   parameter  int MEM_DEPTH      = 2**12,
   parameter  bit CLEAR_ON_RESET = 1'b1,
   localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH * 2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [0:1][7:0]       i_mem_di,
   input  logic [ADDR_WIDTH-1:0] i_mem_addr,
   input  logic                  i_mem_en,
   input  logic                  i_mem_rd_en,
   input  logic [0:1]            i_mem_wr_en,
   output logic [0:1][7:0]       o_mem_do,
   output logic                  o_ready,
   output logic                  o_err
);

   localparam int                   IDX_WIDTH = ADDR_WIDTH - 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(MEM_DEPTH - 1);

   mem_state_t           state;
   logic [IDX_WIDTH-1:0] clr_idx;
   logic                 bus_req;
   logic                 lane_re;
   logic [0:1]           lane_we;
   logic [IDX_WIDTH-1:0] lane_idx;
   halfword_t            lane_di;

   assign bus_req = i_mem_en & (i_mem_rd_en | (|i_mem_wr_en));

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      lane_idx = i_mem_addr[ADDR_WIDTH-1:1];
      lane_di  = i_mem_di;
      lane_we  = '0;
      lane_re  = 1'b0;
      if (rst) begin
         if (state == CLEAR) begin
            lane_idx = clr_idx;
            lane_di  = '0;
            lane_we  = '1;
         end else if (i_mem_en) begin
            lane_we = i_mem_wr_en;
            lane_re = i_mem_rd_en;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= CLEAR_ON_RESET ? CLEAR : READY;
         clr_idx <= '0;
         o_ready <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         // Requests arriving while clearing are dropped and reported like misalignment.
         o_err <= bus_req & ((state == CLEAR) | i_mem_addr[0]);
         if (state == CLEAR) begin
            clr_idx <= clr_idx + IDX_WIDTH'(1);
            if (clr_idx == LAST_IDX) begin
               state   <= READY;
               o_ready <= 1'b1;
            end
         end else begin
            o_ready <= 1'b1;
         end
      end
   end

   mem_lane #(.DEPTH(MEM_DEPTH), .IDX_WIDTH(IDX_WIDTH)) u_lane_even (
      .clk  (clk),
      .rst  (rst),
      .we   (lane_we[LANE_EVEN]),
      .re   (lane_re),
      .idx  (lane_idx),
      .di   (lane_di[LANE_EVEN]),
      .dout (o_mem_do[LANE_EVEN])
   );

   mem_lane #(.DEPTH(MEM_DEPTH), .IDX_WIDTH(IDX_WIDTH)) u_lane_odd (
      .clk  (clk),
      .rst  (rst),
      .we   (lane_we[LANE_ODD]),
      .re   (lane_re),
      .idx  (lane_idx),
      .di   (lane_di[LANE_ODD]),
      .dout (o_mem_do[LANE_ODD])
   );

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder (MEM_DEPTH=16) against a halfword-array
// reference model with a clear-cycle countdown.
module tb_mem_responder;

   localparam int DEPTH = 16;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   di;
   logic [AW-1:0] addr;
   logic          en;
   logic          rd;
   logic [1:0]    wr;
   logic [15:0]   dout;
   logic          ready;
   logic          err;

   always #5 clk = ~clk;

   mem_responder #(.MEM_DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_mem_di    (di),
      .i_mem_addr  (addr),
      .i_mem_en    (en),
      .i_mem_rd_en (rd),
      .i_mem_wr_en (wr),
      .o_mem_do    (dout),
      .o_ready     (ready),
      .o_err       (err)
   );

   // Reference model: bits [15:8] are lane 0 (even byte), [7:0] lane 1 (odd byte).
   logic [15:0] model [DEPTH];
   logic [15:0] exp_do;
   logic        exp_err;
   logic        exp_ready;
   int          clear_left;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // One bus cycle: drive at negedge, advance the model, compare at the next negedge.
   task automatic step(input logic e, input logic r, input logic [1:0] w,
                       input logic [AW-1:0] a, input logic [15:0] d);
      int idx;
      idx  = int'(a[AW-1:1]);
      en   = e;
      rd   = r;
      wr   = w;
      addr = a;
      di   = d;
      exp_err = e && (r || w != 2'b00) && (clear_left > 0 || a[0]);
      if (clear_left > 0) begin
         clear_left--;
         if (clear_left == 0) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
         end
      end else if (e) begin
         if (r) exp_do = model[idx];
         if (w[1]) model[idx][15:8] = d[15:8];
         if (w[0]) model[idx][7:0]  = d[7:0];
      end
      exp_ready = (clear_left == 0);
      @(posedge clk);
      @(negedge clk);
      check("do", 32'(dout), 32'(exp_do));
      check("err", 32'(err), 32'(exp_err));
      check("ready", 32'(ready), 32'(exp_ready));
   endtask

   // Disabled cycles still wiggle rd/wr/addr/data to show en=0 masks everything.
   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b1, 2'b11, AW'($urandom), 16'($urandom));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      en  = 1'b0;
      rd  = 1'b0;
      wr  = 2'b00;
      repeat (n) @(posedge clk);
      @(negedge clk);
      exp_do     = 16'h0000;
      clear_left = DEPTH;
      check("rst_do", 32'(dout), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_ready", 32'(ready), 32'h0);
      rst = 1'b1;
   endtask

   task automatic read_all();
      for (int a = 0; a < 2 * DEPTH; a += 2) step(1'b1, 1'b1, 2'b00, AW'(a), 16'h0000);
   endtask

   initial begin
      rst  = 1'b0;
      en   = 1'b0;
      rd   = 1'b0;
      wr   = 2'b00;
      addr = '0;
      di   = '0;
      @(negedge clk);
      do_reset(3);

      // Read during clear is dropped with an error pulse; then reset at counter 7.
      step(1'b1, 1'b1, 2'b00, 5'h00, 16'h0000);
      idle(6);
      do_reset(2);
      idle(DEPTH);
      read_all();

      // Directed cases: byte lanes, read-first, misalignment, disabled access.
      step(1'b1, 1'b0, 2'b11, 5'h04, 16'hABCD);
      step(1'b1, 1'b1, 2'b00, 5'h04, 16'h0000);
      step(1'b1, 1'b0, 2'b01, 5'h04, 16'h1122);
      step(1'b1, 1'b1, 2'b00, 5'h04, 16'h0000);
      step(1'b1, 1'b1, 2'b11, 5'h08, 16'h1234);
      step(1'b1, 1'b1, 2'b00, 5'h08, 16'h0000);
      step(1'b1, 1'b0, 2'b11, 5'h06, 16'h5AA5);
      step(1'b1, 1'b1, 2'b00, 5'h07, 16'h0000);
      idle(1);
      step(1'b0, 1'b1, 2'b11, 5'h04, 16'hFFFF);
      step(1'b1, 1'b1, 2'b00, 5'h04, 16'h0000);
      step(1'b1, 1'b0, 2'b10, 5'h05, 16'h7700);
      step(1'b1, 1'b1, 2'b00, 5'h04, 16'h0000);

      repeat (400) begin
         step($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
              AW'($urandom), 16'($urandom));
      end

      // A full clear after random traffic must zero the whole array again.
      do_reset(2);
      idle(DEPTH);
      read_all();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
